// File: rtl/fc_seq_pkg.sv
// fc_seq_pkg: state encoding, FC memory bank selects and wait-state helper for the FC train sequencer
package fc_seq_pkg;

    typedef enum logic [3:0] {
        IDLE, FC1, FC2, LABEL, BP_ARM, BP, BP_REL, UPD, UPD_REL
    } state_t;

    localparam logic [1:0] BANK_CONV = 2'b00;
    localparam logic [1:0] BANK_MID  = 2'b10;
    localparam logic [1:0] BANK_OUT  = 2'b11;

    function automatic logic is_wait(input state_t s);
        return s inside {FC1, FC2, LABEL, BP, UPD};
    endfunction

endpackage

// File: rtl/fc_train_sequencer_if.sv
// fc_train_sequencer_if: handshake bundle between the sequencer, the FC engines and the FC memory
interface fc_train_sequencer_if #(
    parameter int CNT_W = 5
);
    logic             sample_start;
    logic             fc1_go;
    logic             fc1_done;
    logic             fc2_go;
    logic             fc2_done;
    logic             label_done;
    logic             fc1_com_end;
    logic             fc2_com_end;
    logic             bck_prop_start;
    logic             fc_bck_prop_end;
    logic             batch_end;
    logic             fc_batch_end;
    logic [CNT_W-1:0] sample_cnt;
    logic             busy;
    logic             sample_done;
    logic             batch_done;
    logic             seq_err;

    modport master (
        input  sample_start, fc1_done, fc2_done, label_done, fc_bck_prop_end, fc_batch_end,
        output fc1_go, fc2_go, fc1_com_end, fc2_com_end, bck_prop_start, batch_end,
               sample_cnt, busy, sample_done, batch_done, seq_err
    );

    modport slave (
        output sample_start, fc1_done, fc2_done, label_done, fc_bck_prop_end, fc_batch_end,
        input  fc1_go, fc2_go, fc1_com_end, fc2_com_end, bck_prop_start, batch_end,
               sample_cnt, busy, sample_done, batch_done, seq_err
    );
endinterface

// File: rtl/fc_seq_watchdog.sv
// fc_seq_watchdog: counts cycles spent in a wait state and pulses o_expire on the TIMEOUT-th one
module fc_seq_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + W'(1);
    end

    assign o_expire = i_en && (r_cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/fc_train_sequencer.sv
// fc_train_sequencer: per-sample / per-batch sequencer driving FC engines and FC memory bank selects
module fc_train_sequencer
    import fc_seq_pkg::*;
#(
    parameter int BATCH_SIZE = 32,
    parameter int TIMEOUT    = 4096
) (
    input logic                  clk,
    input logic                  reset_n,
    fc_train_sequencer_if.master bus
);
    localparam int               CNT_W = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BATCH_SIZE - 1);

    state_t           r_state;
    logic [1:0]       r_bank;
    logic [CNT_W-1:0] r_sample_cnt;
    logic             r_fc1_go, r_fc2_go, r_bck, r_batch_end, r_busy;
    logic             r_sample_done, r_batch_done, r_seq_err;
    logic             w_evt, w_expire;

    // Expected event of the current state; the transient states advance unconditionally
    always_comb
        w_evt = (r_state == IDLE)  ? bus.sample_start    :
                (r_state == FC1)   ? bus.fc1_done        :
                (r_state == FC2)   ? bus.fc2_done        :
                (r_state == LABEL) ? bus.label_done      :
                (r_state == BP)    ? bus.fc_bck_prop_end :
                (r_state == UPD)   ? bus.fc_batch_end    : 1'b1;

    fc_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (w_evt | w_expire),
        .i_en     (is_wait(r_state)),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_bank        <= BANK_CONV;
            r_sample_cnt  <= '0;
            r_fc1_go      <= 1'b0;
            r_fc2_go      <= 1'b0;
            r_bck         <= 1'b0;
            r_batch_end   <= 1'b0;
            r_busy        <= 1'b0;
            r_sample_done <= 1'b0;
            r_batch_done  <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            r_fc1_go      <= 1'b0;
            r_fc2_go      <= 1'b0;
            r_sample_done <= 1'b0;
            r_batch_done  <= 1'b0;
            if (w_evt) begin
                case (r_state)
                    IDLE: begin
                        r_state  <= FC1;
                        r_fc1_go <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                    FC1: begin
                        r_state  <= FC2;
                        r_fc2_go <= 1'b1;
                        r_bank   <= BANK_MID;
                    end
                    FC2: begin
                        r_state <= LABEL;
                        r_bank  <= BANK_OUT;
                    end
                    LABEL: r_state <= BP_ARM;
                    BP_ARM: begin
                        r_state <= BP;
                        r_bck   <= 1'b1;
                    end
                    BP: begin
                        r_state       <= BP_REL;
                        r_bck         <= 1'b0;
                        r_sample_done <= 1'b1;
                    end
                    BP_REL: begin
                        if (r_sample_cnt == LAST) begin
                            r_state     <= UPD;
                            r_batch_end <= 1'b1;
                        end else begin
                            r_state      <= IDLE;
                            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                            r_bank       <= BANK_CONV;
                            r_busy       <= 1'b0;
                        end
                    end
                    UPD: begin
                        r_state      <= UPD_REL;
                        r_batch_end  <= 1'b0;
                        r_batch_done <= 1'b1;
                    end
                    UPD_REL: begin
                        r_state      <= IDLE;
                        r_sample_cnt <= '0;
                        r_bank       <= BANK_CONV;
                        r_busy       <= 1'b0;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (w_expire) begin
                r_state     <= IDLE;
                r_seq_err   <= 1'b1;
                r_bank      <= BANK_CONV;
                r_bck       <= 1'b0;
                r_batch_end <= 1'b0;
                r_busy      <= 1'b0;
            end
        end
    end

    assign bus.fc1_go         = r_fc1_go;
    assign bus.fc2_go         = r_fc2_go;
    assign bus.fc1_com_end    = r_bank[1];
    assign bus.fc2_com_end    = r_bank[0];
    assign bus.bck_prop_start = r_bck;
    assign bus.batch_end      = r_batch_end;
    assign bus.sample_cnt     = r_sample_cnt;
    assign bus.busy           = r_busy;
    assign bus.sample_done    = r_sample_done;
    assign bus.batch_done     = r_batch_done;
    assign bus.seq_err        = r_seq_err;
endmodule

// File: tb/tb_fc_train_sequencer.sv
// tb_fc_train_sequencer: randomized sample/batch traffic with a queue scoreboard of completion pulses
module tb_fc_train_sequencer;
    import fc_seq_pkg::*;

    localparam int BS = 32;
    localparam int TO = 4096;

    typedef struct {bit batch; int cnt;} exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fc_train_sequencer_if #(.CNT_W(5)) bus ();
    fc_train_sequencer_if #(.CNT_W(1)) b1 ();

    fc_train_sequencer #(.BATCH_SIZE(BS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    fc_train_sequencer #(.BATCH_SIZE(1), .TIMEOUT(1024)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1)
    );

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int outs();
        return 32'({bus.fc1_go, bus.fc2_go, bus.fc1_com_end, bus.fc2_com_end, bus.bck_prop_start,
                    bus.batch_end, bus.sample_cnt, bus.busy, bus.sample_done, bus.batch_done, bus.seq_err});
    endfunction

    function automatic int bank();
        return 32'({bus.fc1_com_end, bus.fc2_com_end});
    endfunction

    always @(negedge clk) begin
        if (reset_n && (bus.sample_done || bus.batch_done)) begin
            if (sb.size() == 0) check("unexpected_done", 32'({bus.sample_done, bus.batch_done}), 0);
            else begin
                e = sb.pop_front();
                check("done_kind", 32'({bus.sample_done, bus.batch_done}), e.batch ? 1 : 2);
                if (!e.batch) check("cnt_at_sample_done", 32'(bus.sample_cnt), e.cnt);
            end
        end
    end

    task automatic front(input bit spur);
        int d;
        bus.sample_start = 1'b1;
        @(negedge clk);
        bus.sample_start = 1'b0;
        check("fc1_go", 32'(bus.fc1_go), 1);
        check("bank_fc1", bank(), 32'(BANK_CONV));
        check("busy", 32'(bus.busy), 1);
        d = $urandom_range(0, 4);
        repeat (d) begin
            bus.label_done = spur & 1'($urandom_range(0, 1));
            @(negedge clk);
            check("fc1_go_pulse", 32'(bus.fc1_go), 0);
        end
        bus.label_done = 1'b0;
        bus.fc1_done = 1'b1;
        @(negedge clk);
        bus.fc1_done = 1'b0;
        check("fc2_go", 32'(bus.fc2_go), 1);
        check("bank_fc2", bank(), 32'(BANK_MID));
        d = $urandom_range(0, 4);
        repeat (d) begin
            bus.sample_start = spur & 1'($urandom_range(0, 1));
            bus.fc1_done     = spur & 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bank_fc2_hold", bank(), 32'(BANK_MID));
        end
        {bus.sample_start, bus.fc1_done} = '0;
        bus.fc2_done = 1'b1;
        @(negedge clk);
        bus.fc2_done = 1'b0;
        check("bank_label", bank(), 32'(BANK_OUT));
        d = $urandom_range(0, 4);
        repeat (d) begin
            bus.fc1_done = spur & 1'($urandom_range(0, 1));
            bus.fc2_done = spur & 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_low_in_label", 32'(bus.bck_prop_start), 0);
        end
        {bus.fc1_done, bus.fc2_done} = '0;
        bus.label_done = 1'b1;
        @(negedge clk);
        bus.label_done = 1'b0;
        check("bp_arm_low", 32'(bus.bck_prop_start), 0);
        @(negedge clk);
        check("bp_high", 32'(bus.bck_prop_start), 1);
    endtask

    task automatic back(input bit spur);
        int d, n;
        bit bat;
        d = $urandom_range(0, 5);
        repeat (d) begin
            bus.sample_start = spur & 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_hold", 32'(bus.bck_prop_start), 1);
        end
        bus.sample_start = 1'b0;
        sb.push_back('{1'b0, done_cnt});
        done_cnt++;
        bat = (done_cnt == BS);
        if (bat) begin
            sb.push_back('{1'b1, 0});
            done_cnt = 0;
        end
        bus.fc_bck_prop_end = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.bck_prop_start && n < 16);
        check("bp_release", 32'(bus.bck_prop_start), 0);
        bus.fc_bck_prop_end = 1'b0;
        @(negedge clk);
        check("batch_end", 32'(bus.batch_end), 32'(bat));
        if (bat) begin
            d = $urandom_range(0, 5);
            repeat (d) begin
                @(negedge clk);
                check("upd_hold", 32'(bus.batch_end), 1);
            end
            bus.fc_batch_end = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (bus.batch_end && n < 16);
            check("upd_release", 32'(bus.batch_end), 0);
            bus.fc_batch_end = 1'b0;
            @(negedge clk);
        end
        check("idle_after_sample", 32'(bus.busy), 0);
        check("cnt_after_sample", 32'(bus.sample_cnt), done_cnt);
    endtask

    task automatic run_b1();
        b1.sample_start = 1'b1;
        @(negedge clk);
        b1.sample_start = 1'b0;
        check("b1_fc1_go", 32'(b1.fc1_go), 1);
        b1.fc1_done = 1'b1;
        @(negedge clk);
        b1.fc1_done = 1'b0;
        b1.fc2_done = 1'b1;
        @(negedge clk);
        b1.fc2_done = 1'b0;
        b1.label_done = 1'b1;
        @(negedge clk);
        b1.label_done = 1'b0;
        @(negedge clk);
        check("b1_bp_high", 32'(b1.bck_prop_start), 1);
        b1.fc_bck_prop_end = 1'b1;
        @(negedge clk);
        b1.fc_bck_prop_end = 1'b0;
        check("b1_sample_done", 32'({b1.sample_done, b1.sample_cnt}), 2);
        @(negedge clk);
        check("b1_batch_end", 32'(b1.batch_end), 1);
        b1.fc_batch_end = 1'b1;
        @(negedge clk);
        b1.fc_batch_end = 1'b0;
        check("b1_batch_done", 32'({b1.batch_done, b1.batch_end}), 2);
        @(negedge clk);
        check("b1_idle", 32'({b1.busy, b1.sample_cnt}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        {bus.sample_start, bus.fc1_done, bus.fc2_done, bus.label_done, bus.fc_bck_prop_end, bus.fc_batch_end} = '0;
        {b1.sample_start, b1.fc1_done, b1.fc2_done, b1.label_done, b1.fc_bck_prop_end, b1.fc_batch_end} = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            {bus.fc1_done, bus.fc2_done, bus.label_done, bus.fc_bck_prop_end, bus.fc_batch_end} = 5'(1 << i);
            @(negedge clk);
            {bus.fc1_done, bus.fc2_done, bus.label_done, bus.fc_bck_prop_end, bus.fc_batch_end} = '0;
            check("idle_spurious", outs(), 0);
        end
        for (int i = 0; i < BS; i++) begin
            front(1'($urandom_range(0, 1)));
            back(1'($urandom_range(0, 1)));
        end
        check("cnt_after_batch", 32'(bus.sample_cnt), 0);
        bus.sample_start = 1'b1;
        @(negedge clk);
        bus.sample_start = 1'b0;
        bus.fc1_done = 1'b1;
        @(negedge clk);
        bus.fc1_done = 1'b0;
        check("stall_bank_fc2", bank(), 32'(BANK_MID));
        n = 0;
        while (bus.busy && n < TO + 16) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_seq_err", 32'(bus.seq_err), 1);
        check("timeout_bank", bank(), 32'(BANK_CONV));
        check("timeout_cnt", 32'(bus.sample_cnt), 0);
        for (int i = 0; i < 7; i++) begin
            front(1'b1);
            back(1'b1);
            check("seq_err_sticky", 32'(bus.seq_err), 1);
        end
        front(1'b0);
        check("pre_reset_cnt", 32'(bus.sample_cnt), 7);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", outs(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        done_cnt = 0;
        sb.delete();
        @(negedge clk);
        check("post_reset_outputs", outs(), 0);
        for (int i = 0; i < 3; i++) begin
            front(1'b1);
            back(1'b1);
        end
        run_b1();
        run_b1();
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
